// File: rtl/rmii_rx_framer_pkg.sv
// Shared types and constants for the RMII receive framer.
// FSM state encoding, preamble/SFD dibits, CRC residue and error-flag bit positions.
package rmii_rx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        DROP = 2'd3
    } state_t;

    localparam logic [1:0]  DIBIT_PRE   = 2'b01;
    localparam logic [1:0]  DIBIT_SFD   = 2'b11;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    // Bit positions inside o_err_flags = {crc_bad, align, runt, oversize}
    localparam int ERR_CRC_BAD  = 3;
    localparam int ERR_ALIGN    = 2;
    localparam int ERR_RUNT     = 1;
    localparam int ERR_OVERSIZE = 0;

endpackage

// File: rtl/rmii_rx_framer_if.sv
// Bundle of RMII input, CRC engine handshake and byte-stream output signals.
// master = framer side, slave = PHY/CRC engine/parser side.
interface rmii_rx_framer_if;

    logic        i_crs_dv;
    logic [1:0]  i_rxd;
    logic        o_crc_init;
    logic        o_drive_crc;
    logic [1:0]  o_crc_rxd;
    logic [31:0] i_calculated_crc;
    logic [7:0]  o_data;
    logic        o_valid;
    logic        o_sof;
    logic        o_eof;
    logic        o_crc_ok;
    logic [3:0]  o_err_flags;

    modport master (
        input  i_crs_dv, i_rxd, i_calculated_crc,
        output o_crc_init, o_drive_crc, o_crc_rxd,
        output o_data, o_valid, o_sof, o_eof, o_crc_ok, o_err_flags
    );

    modport slave (
        output i_crs_dv, i_rxd, i_calculated_crc,
        input  o_crc_init, o_drive_crc, o_crc_rxd,
        input  o_data, o_valid, o_sof, o_eof, o_crc_ok, o_err_flags
    );

endinterface

// File: rtl/rmii_rx_framer_byte_assembler.sv
// Packs LSB-first dibits into bytes and keeps one byte in a hold register so
// the frame's last byte can leave together with its eof status.
module rmii_byte_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        shift,
    input  logic        flush,
    input  logic        clear,
    input  logic [1:0]  dibit,
    input  logic        eof_crc_ok,
    input  logic [3:0]  eof_flags,
    output logic [1:0]  k,
    output logic [10:0] byte_cnt,
    output logic [7:0]  data,
    output logic        valid,
    output logic        sof,
    output logic        eof,
    output logic        crc_ok,
    output logic [3:0]  err_flags
);
    import rmii_rx_pkg::*;

    logic [5:0] sr;
    logic [7:0] hold;
    logic       hold_full;
    logic       first;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k         <= '0;
            byte_cnt  <= '0;
            sr        <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            first     <= 1'b1;
            data      <= '0;
            valid     <= 1'b0;
            sof       <= 1'b0;
            eof       <= 1'b0;
            crc_ok    <= 1'b0;
            err_flags <= '0;
        end else begin
            valid     <= 1'b0;
            sof       <= 1'b0;
            eof       <= 1'b0;
            crc_ok    <= 1'b0;
            err_flags <= '0;
            // flush outranks shift so the byte past the size limit is never loaded
            if (flush) begin
                if (hold_full) begin
                    valid     <= 1'b1;
                    data      <= hold;
                    sof       <= first;
                    eof       <= 1'b1;
                    crc_ok    <= eof_crc_ok;
                    err_flags <= eof_flags;
                end
                k         <= '0;
                byte_cnt  <= '0;
                hold_full <= 1'b0;
                first     <= 1'b1;
            end else if (shift) begin
                k <= k + 2'd1;
                if (k == 2'd3) begin
                    if (hold_full) begin
                        valid <= 1'b1;
                        data  <= hold;
                        sof   <= first;
                        first <= 1'b0;
                    end
                    hold      <= {dibit, sr};
                    hold_full <= 1'b1;
                    byte_cnt  <= byte_cnt + 11'd1;
                end else begin
                    sr <= {dibit, sr[5:2]};
                end
            end else if (clear) begin
                k         <= '0;
                byte_cnt  <= '0;
                hold_full <= 1'b0;
                first     <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/rmii_rx_framer.sv
// RMII receive framer: preamble/SFD hunt, CRC engine control, byte assembly
// and end-of-frame status (crc, alignment, runt, oversize).
module rmii_rx_framer #(
    parameter int          MIN_PREAMBLE_DIBITS = 4,
    parameter int          MIN_FRAME_BYTES     = 64,
    parameter int          MAX_FRAME_BYTES     = 1518,
    parameter logic [31:0] CRC_RESIDUE         = rmii_rx_pkg::CRC_RESIDUE
) (
    input  logic               i_rmii_clk,
    input  logic               i_rstn,
    rmii_rx_framer_if.master   bus
);
    import rmii_rx_pkg::*;

    state_t      state, state_nxt;
    logic        r_dv;
    logic [1:0]  r_rxd;
    logic [7:0]  pre_cnt;
    logic [1:0]  k;
    logic [10:0] byte_cnt;
    logic        over;
    logic        crc_init, drive_crc, flush, clear;
    logic        eof_ok;
    logic [3:0]  eof_flags;

    always_ff @(posedge i_rmii_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_dv  <= 1'b0;
            r_rxd <= '0;
        end else begin
            r_dv  <= bus.i_crs_dv;
            r_rxd <= bus.i_rxd;
        end
    end

    always_ff @(posedge i_rmii_clk or negedge i_rstn) begin
        if (!i_rstn) state <= IDLE;
        else         state <= state_nxt;
    end

    // IDLE preloads 1 so the dibit that triggers IDLE->PRE is already counted
    always_ff @(posedge i_rmii_clk or negedge i_rstn) begin
        if (!i_rstn)
            pre_cnt <= '0;
        else if (state == IDLE)
            pre_cnt <= 8'd1;
        else if (state == PRE && r_rxd == DIBIT_PRE && pre_cnt != 8'hFF)
            pre_cnt <= pre_cnt + 8'd1;
    end

    assign over = (state == DATA) && r_dv && (k == 2'd3) &&
                  (byte_cnt == 11'(MAX_FRAME_BYTES));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (r_dv) state_nxt = (r_rxd == DIBIT_PRE) ? PRE : DROP;
            PRE: begin
                if (!r_dv)
                    state_nxt = IDLE;
                else if (r_rxd == DIBIT_PRE)
                    state_nxt = PRE;
                else if (r_rxd == DIBIT_SFD && int'(pre_cnt) >= MIN_PREAMBLE_DIBITS)
                    state_nxt = DATA;
                else
                    state_nxt = DROP;
            end
            DATA: begin
                if (!r_dv)     state_nxt = IDLE;
                else if (over) state_nxt = DROP;
            end
            DROP: if (!r_dv) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        crc_init  = 1'b1;
        drive_crc = 1'b0;
        flush     = 1'b0;
        clear     = 1'b1;
        eof_ok    = 1'b0;
        eof_flags = '0;
        if (state == DATA) begin
            crc_init  = 1'b0;
            clear     = 1'b0;
            drive_crc = r_dv;
            flush     = !r_dv || over;
            // truncated frames never report crc status, only oversize
            if (over) begin
                eof_flags[ERR_OVERSIZE] = 1'b1;
            end else begin
                eof_ok                 = (bus.i_calculated_crc == CRC_RESIDUE);
                eof_flags[ERR_CRC_BAD] = !eof_ok;
                eof_flags[ERR_ALIGN]   = (k != 2'd0);
                eof_flags[ERR_RUNT]    = (int'(byte_cnt) < MIN_FRAME_BYTES);
            end
        end
    end

    assign bus.o_crc_init  = crc_init;
    assign bus.o_drive_crc = drive_crc;
    assign bus.o_crc_rxd   = r_rxd;

    rmii_byte_assembler u_asm (
        .clk        (i_rmii_clk),
        .rst_n      (i_rstn),
        .shift      (drive_crc),
        .flush      (flush),
        .clear      (clear),
        .dibit      (r_rxd),
        .eof_crc_ok (eof_ok),
        .eof_flags  (eof_flags),
        .k          (k),
        .byte_cnt   (byte_cnt),
        .data       (bus.o_data),
        .valid      (bus.o_valid),
        .sof        (bus.o_sof),
        .eof        (bus.o_eof),
        .crc_ok     (bus.o_crc_ok),
        .err_flags  (bus.o_err_flags)
    );

endmodule
